// File: rtl/mips_pkg.sv
// mips_pkg: shared fetch-state encoding, PC increment, opcode constants
// and the word-alignment helper used by the MIPS front end.
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } fetch_state_t;

    localparam logic [31:0] PC_INCR = 32'd4;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & ~32'h3;
    endfunction

endpackage

// File: rtl/flopenr.sv
// flopenr: enable flop with asynchronous active-high reset to a
// parameterised reset value.
module flopenr #(
    parameter int           W         = 32,
    parameter logic [W-1:0] RESET_VAL = '0
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)   q_o <= RESET_VAL;
        else if (en_i) q_o <= d_i;
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: MIPS instruction fetch; PC, imem req/ack, instruction register
// with valid/ready to decode, and redirect handling that never abandons a request.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d, pending_q, redir;
    logic         pc_en, pending_en, instr_en;

    assign redir = word_align(redirect_pc);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // pending holds the latest redirect target while an old request drains
    always_comb begin
        state_d    = state_q;
        pc_en      = 1'b0;
        pc_d       = pc_q + PC_INCR;
        pending_en = 1'b0;
        instr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = REQ;
                pc_en   = redirect_valid;
                pc_d    = redir;
            end
            REQ: begin
                if (imem_ack && !redirect_valid) begin
                    instr_en = 1'b1;
                    pc_en    = 1'b1;
                    state_d  = HOLD;
                end else if (imem_ack) begin
                    pc_en = 1'b1;
                    pc_d  = redir;
                end else if (redirect_valid) begin
                    pending_en = 1'b1;
                    state_d    = DRAIN;
                end
            end
            DRAIN: begin
                pending_en = redirect_valid;
                if (imem_ack) begin
                    pc_en   = 1'b1;
                    pc_d    = redirect_valid ? redir : pending_q;
                    state_d = REQ;
                end
            end
            HOLD: begin
                pc_en   = redirect_valid;
                pc_d    = redir;
                state_d = (redirect_valid || instr_ready) ? REQ : HOLD;
            end
            default: state_d = IDLE;
        endcase
    end

    flopenr #(.W(32), .RESET_VAL(RESET_PC)) u_pc (
        .clk_i(clk), .reset_i(reset), .en_i(pc_en), .d_i(pc_d), .q_o(pc_q)
    );

    flopenr #(.W(32), .RESET_VAL(RESET_PC)) u_pending (
        .clk_i(clk), .reset_i(reset), .en_i(pending_en), .d_i(redir), .q_o(pending_q)
    );

    flopenr #(.W(32), .RESET_VAL(32'h0)) u_instr (
        .clk_i(clk), .reset_i(reset), .en_i(instr_en), .d_i(imem_rdata), .q_o(instr)
    );

    flopenr #(.W(32), .RESET_VAL(32'h0)) u_instr_pc (
        .clk_i(clk), .reset_i(reset), .en_i(instr_en), .d_i(pc_q), .q_o(instr_pc)
    );

    assign imem_req    = (state_q == REQ) || (state_q == DRAIN);
    assign imem_addr   = pc_q;
    assign instr_valid = (state_q == HOLD);
    assign pc_plus4    = instr_pc + PC_INCR;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scoreboard bench; stimulus queues expected fetch
// addresses and decode transfers, a negedge monitor pops and compares them.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req, imem_ack = 1'b0;
    logic [31:0] imem_addr, imem_rdata = '0;
    logic [31:0] instr, instr_pc, pc_plus4;
    logic        instr_valid, instr_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;

    logic        w_reset = 1'b1;
    logic        w_req, w_ack = 1'b0, w_valid, w_ready = 1'b0;
    logic [31:0] w_addr, w_rdata = '0, w_instr, w_instr_pc, w_pc_plus4;

    int total = 0;
    int bad = 0;
    logic [31:0] aq[$];
    logic [63:0] iq[$];

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr),
        .instr_pc(instr_pc), .pc_plus4(pc_plus4), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk(clk), .reset(w_reset), .imem_req(w_req), .imem_addr(w_addr),
        .imem_ack(w_ack), .imem_rdata(w_rdata), .instr(w_instr),
        .instr_pc(w_instr_pc), .pc_plus4(w_pc_plus4), .instr_valid(w_valid),
        .instr_ready(w_ready), .redirect_valid(1'b0), .redirect_pc(32'h0)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // monitor: every accepted memory request and every decode transfer
    always @(negedge clk) begin
        if (!reset) begin
            if (imem_req && imem_ack) begin
                if (aq.size() == 0) chk("unexpected_ack_addr", {32'h0, imem_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
                else chk("ack_addr", {32'h0, imem_addr}, {32'h0, aq.pop_front()});
            end
            if (instr_valid && instr_ready) begin
                if (iq.size() == 0) chk("unexpected_xfer", {instr, instr_pc}, 64'hFFFF_FFFF_FFFF_FFFF);
                else chk("xfer_instr_pc", {instr, instr_pc}, iq.pop_front());
            end
        end
    end

    // entered in REQ at posedge+1; returns at posedge+1 after the ack cycle
    task automatic do_fetch(input logic [31:0] a, input logic [31:0] w, input int waits, input bit xfer);
        aq.push_back(a);
        if (xfer) iq.push_back({w, a});
        for (int i = 0; i < waits; i++) begin
            @(negedge clk);
            chk("wait_req", {63'h0, imem_req}, 64'h1);
            chk("wait_addr", {32'h0, imem_addr}, {32'h0, a});
            tick();
        end
        imem_ack = 1'b1;
        imem_rdata = w;
        @(negedge clk);
        chk("ack_req", {63'h0, imem_req}, 64'h1);
        tick();
        imem_ack = 1'b0;
    endtask

    initial begin
        // reset and first fetch
        repeat (3) tick();
        @(negedge clk);
        chk("rst_req", {63'h0, imem_req}, 64'h0);
        chk("rst_valid", {63'h0, instr_valid}, 64'h0);
        chk("rst_addr", {32'h0, imem_addr}, 64'h0);
        chk("rst_instr", {instr, instr_pc}, 64'h0);
        chk("rst_pc_plus4", {32'h0, pc_plus4}, 64'h4);
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("idle_req", {63'h0, imem_req}, 64'h0);
        tick();
        @(negedge clk);
        chk("first_req", {63'h0, imem_req}, 64'h1);
        chk("first_addr", {32'h0, imem_addr}, 64'h0);
        @(posedge clk);
        #1;
        do_fetch(32'h0, 32'h8C08_0004, 0, 1'b1);
        @(negedge clk);
        chk("first_instr", {instr, instr_pc}, {32'h8C08_0004, 32'h0});
        chk("first_pc_plus4", {32'h0, pc_plus4}, 64'h4);
        chk("first_valid", {63'h0, instr_valid}, 64'h1);
        chk("first_opcode", {58'h0, instr[31:26]}, {58'h0, 6'b100011});
        // back-pressure
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge clk);
            chk("bp_instr", {instr, instr_pc}, {32'h8C08_0004, 32'h0});
            chk("bp_req_valid", {62'h0, imem_req, instr_valid}, 64'h1);
        end
        tick();
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        @(negedge clk);
        chk("bp_next_req", {63'h0, imem_req}, 64'h1);
        chk("bp_next_addr", {32'h0, imem_addr}, 64'h4);
        @(posedge clk);
        #1;
        // wait-state memory
        do_fetch(32'h4, 32'h2008_0005, 3, 1'b1);
        @(negedge clk);
        chk("ws_valid", {63'h0, instr_valid}, 64'h1);
        tick();
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        // redirect twice while request for 8 is outstanding
        aq.push_back(32'h8);
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        @(negedge clk);
        chk("rd_addr0", {31'h0, imem_req, imem_addr}, {31'h0, 1'b1, 32'h8});
        tick();
        redirect_pc = 32'h80;
        @(negedge clk);
        chk("rd_addr1", {31'h0, imem_req, imem_addr}, {31'h0, 1'b1, 32'h8});
        tick();
        redirect_valid = 1'b0;
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("rd_addr2", {31'h0, imem_req, imem_addr}, {31'h0, 1'b1, 32'h8});
        tick();
        imem_ack = 1'b0;
        @(negedge clk);
        chk("rd_discard_valid", {63'h0, instr_valid}, 64'h0);
        chk("rd_new_addr", {31'h0, imem_req, imem_addr}, {31'h0, 1'b1, 32'h80});
        @(posedge clk);
        #1;
        do_fetch(32'h80, 32'h1109_0003, 0, 1'b0);
        @(negedge clk);
        chk("hold_instr", {instr, instr_pc}, {32'h1109_0003, 32'h80});
        chk("hold_pc_plus4", {32'h0, pc_plus4}, 64'h84);
        // redirect in HOLD squashes the held instruction
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h103;
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("sq_valid", {63'h0, instr_valid}, 64'h0);
        chk("sq_addr", {31'h0, imem_req, imem_addr}, {31'h0, 1'b1, 32'h100});
        // redirect coincident with ack
        @(posedge clk);
        #1;
        aq.push_back(32'h100);
        imem_ack = 1'b1;
        imem_rdata = 32'hAC0A_0000;
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        tick();
        imem_ack = 1'b0;
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("co_valid", {63'h0, instr_valid}, 64'h0);
        chk("co_addr", {31'h0, imem_req, imem_addr}, {31'h0, 1'b1, 32'h200});
        @(posedge clk);
        #1;
        do_fetch(32'h200, 32'h0800_0040, 0, 1'b1);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        // async reset mid-DRAIN
        redirect_valid = 1'b1;
        redirect_pc = 32'h300;
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("drain_addr", {31'h0, imem_req, imem_addr}, {31'h0, 1'b1, 32'h204});
        #1;
        reset = 1'b1;
        #1;
        chk("ar_req_valid", {62'h0, imem_req, instr_valid}, 64'h0);
        chk("ar_addr", {32'h0, imem_addr}, 64'h0);
        chk("ar_instr", {instr, instr_pc}, 64'h0);
        chk("ar_pc_plus4", {32'h0, pc_plus4}, 64'h4);
        #1;
        reset = 1'b0;
        tick();
        @(negedge clk);
        chk("ar_restart", {31'h0, imem_req, imem_addr}, {31'h0, 1'b1, 32'h0});
        // PC wrap on second instance
        @(posedge clk);
        #1;
        w_reset = 1'b0;
        tick();
        @(negedge clk);
        chk("wrap_first", {31'h0, w_req, w_addr}, {31'h0, 1'b1, 32'hFFFF_FFFC});
        @(posedge clk);
        #1;
        w_ack = 1'b1;
        w_rdata = 32'h0000_0020;
        tick();
        w_ack = 1'b0;
        @(negedge clk);
        chk("wrap_instr_pc", {w_instr, w_instr_pc}, {32'h0000_0020, 32'hFFFF_FFFC});
        chk("wrap_pc_plus4", {32'h0, w_pc_plus4}, 64'h0);
        @(posedge clk);
        #1;
        w_ready = 1'b1;
        tick();
        w_ready = 1'b0;
        @(negedge clk);
        chk("wrap_second", {31'h0, w_req, w_addr}, {31'h0, 1'b1, 32'h0});
        chk("aq_empty", 64'(aq.size()), 64'h0);
        chk("iq_empty", 64'(iq.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
